// File: rtl/add_sub_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// add_sub_pkg : shared state encoding and mode constants for serial_add_sub
// Rev 1.0
// ---------------------------------------------------------------------------
package add_sub_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/digit_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// digit_adder : combinational DIGIT-bit ripple adder with carry in/out
// Rev 1.0
// ---------------------------------------------------------------------------
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_s,
  output logic             o_cout
);

  logic w_carry;

  always_comb begin
    w_carry = i_cin;
    o_s     = '0;
    for (int i = 0; i < DIGIT; i++) begin
      o_s[i]  = i_a[i] ^ i_b[i] ^ w_carry;
      w_carry = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_carry;
  end

endmodule
`default_nettype wire

// File: rtl/serial_add_sub.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_add_sub : digit-serial adder/subtractor with start/busy/done handshake
// Rev 1.0
// ---------------------------------------------------------------------------
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             m,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int c_n  = WIDTH / DIGIT;
  localparam int c_cw = (c_n > 1) ? $clog2(c_n) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(c_n - 1);

  state_t            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_res;
  logic              r_carry;
  logic              r_a_msb;
  logic              r_bm_msb;
  logic [c_cw-1:0]   r_cnt;
  logic              r_done;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;
  logic              r_zero;

  logic [WIDTH-1:0]  w_bm;
  logic [DIGIT-1:0]  w_dsum;
  logic              w_dcout;
  logic [WIDTH-1:0]  w_res_next;
  logic              w_last;

  // Subtraction is a + ~b + 1: invert b here, the +1 enters as initial carry.
  assign w_bm   = (m == MODE_SUB) ? ~b : b;
  assign w_last = (r_cnt == c_last);
  // Result fills from the top so the final digit lands in the MSBs.
  assign w_res_next = (r_res >> DIGIT) | (WIDTH'(w_dsum) << (WIDTH - DIGIT));

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .i_a    (r_a[DIGIT-1:0]),
    .i_b    (r_b[DIGIT-1:0]),
    .i_cin  (r_carry),
    .o_s    (w_dsum),
    .o_cout (w_dcout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_carry  <= 1'b0;
      r_a_msb  <= 1'b0;
      r_bm_msb <= 1'b0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state  <= ST_RUN;
            r_a      <= a;
            r_b      <= w_bm;
            r_carry  <= (m == MODE_SUB);
            r_a_msb  <= a[WIDTH-1];
            r_bm_msb <= w_bm[WIDTH-1];
            r_cnt    <= '0;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_res   <= w_res_next;
          r_carry <= w_dcout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
            r_sum   <= w_res_next;
            r_cout  <= w_dcout;
            r_zero  <= (w_res_next == '0);
            r_ovf   <= (r_a_msb == r_bm_msb) & (w_res_next[WIDTH-1] != r_a_msb);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_add_sub : bench for three configurations (4/1, 8/2, 16/16)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        st4, m4, busy4, done4, cout4, ovf4, zero4;
  logic [3:0]  a4, b4, s4;
  logic        st8, m8, busy8, done8, cout8, ovf8, zero8;
  logic [7:0]  a8, b8, s8;
  logic        st16, m16, busy16, done16, cout16, ovf16, zero16;
  logic [15:0] a16, b16, s16;

  serial_add_sub #(.WIDTH(4), .DIGIT(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .m(m4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(s4), .cout(cout4), .ovf(ovf4), .zero(zero4));
  serial_add_sub #(.WIDTH(8), .DIGIT(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .m(m8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(s8), .cout(cout8), .ovf(ovf8), .zero(zero8));
  serial_add_sub #(.WIDTH(16), .DIGIT(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .m(m16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(s16), .cout(cout16), .ovf(ovf16), .zero(zero16));

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [15:0] sum;
  } obs_t;

  typedef struct {
    int          sel;
    logic        m;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic int width_of(input int sel);
    return (sel == 0) ? 4 : (sel == 1) ? 8 : 16;
  endfunction

  function automatic int lat_of(input int sel);
    return (sel == 2) ? 1 : 4;
  endfunction

  function automatic obs_t obs(input int sel);
    obs_t o;
    case (sel)
      0:       o = {busy4, done4, cout4, ovf4, zero4, 12'h000, s4};
      1:       o = {busy8, done8, cout8, ovf8, zero8, 8'h00, s8};
      default: o = {busy16, done16, cout16, ovf16, zero16, s16};
    endcase
    return o;
  endfunction

  task automatic drive(input int sel, input logic s, input logic mm,
                       input logic [15:0] aa, input logic [15:0] bb);
    case (sel)
      0:       begin st4 = s;  m4 = mm;  a4 = aa[3:0]; b4 = bb[3:0]; end
      1:       begin st8 = s;  m8 = mm;  a8 = aa[7:0]; b8 = bb[7:0]; end
      default: begin st16 = s; m16 = mm; a16 = aa;     b16 = bb;     end
    endcase
  endtask

  task automatic drive_junk(input int sel, input logic s);
    drive(sel, s, 1'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input int w, input logic mm, input logic [15:0] aa, input logic [15:0] bb,
                       output logic [15:0] s, output logic c, output logic o, output logic z);
    longint md, ua, ub, sa, sb, r, sr;
    md = longint'(1) << w;
    ua = longint'(aa) % md;
    ub = longint'(bb) % md;
    sa = (ua >= md / 2) ? ua - md : ua;
    sb = (ub >= md / 2) ? ub - md : ub;
    if (mm == 1'b0) begin
      r = ua + ub;
      c = (r >= md);
      sr = sa + sb;
    end else begin
      r = ua - ub;
      c = (ua >= ub);
      sr = sa - sb;
    end
    s = 16'(((r % md) + md) % md);
    o = (sr < -(md / 2)) || (sr >= md / 2);
    z = (s == 16'h0);
  endtask

  task automatic op(input int sel, input logic mm, input logic [15:0] aa, input logic [15:0] bb,
                    input logic [15:0] es, input logic ec, input logic eo, input logic ez,
                    input string tag);
    int   lat;
    obs_t o;
    @(negedge clk);
    drive(sel, 1'b1, mm, aa, bb);
    @(posedge clk);
    #1;
    drive_junk(sel, 1'b0);
    o = obs(sel);
    chk({tag, " busy_after_start"}, 32'(o.busy), 32'd1);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      o = obs(sel);
    end while (!o.done && lat < 20);
    chk({tag, " latency"}, 32'(lat), 32'(lat_of(sel)));
    chk({tag, " sum"},  32'(o.sum),  32'(es));
    chk({tag, " cout"}, 32'(o.cout), 32'(ec));
    chk({tag, " ovf"},  32'(o.ovf),  32'(eo));
    chk({tag, " zero"}, 32'(o.zero), 32'(ez));
    chk({tag, " busy_at_done"}, 32'(o.busy), 32'd0);
    @(posedge clk);
    #1;
    o = obs(sel);
    chk({tag, " done_one_cycle"}, 32'(o.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [10];
    obs_t        o, hold;
    logic [15:0] es, ra, rb;
    logic        ec, eo, ez, rm;
    logic [15:0] qa [4];
    logic [15:0] qb [4];
    logic        qm [4];
    int          cur, cyc;

    tbl[0] = '{0, 1'b0, 16'h0009, 16'h000A, 16'h0003, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{0, 1'b1, 16'h0009, 16'h000A, 16'h000F, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{0, 1'b0, 16'h0007, 16'h0001, 16'h0008, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1, 1'b0, 16'h007F, 16'h0001, 16'h0080, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1, 1'b1, 16'h0080, 16'h0080, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1, 1'b1, 16'h0000, 16'h0001, 16'h00FF, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1, 1'b0, 16'h0080, 16'h0080, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{2, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{2, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{2, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 16'h0, 16'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) chk($sformatf("reset_state dut%0d", s), 32'(obs(s)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      op(tbl[i].sel, tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, tbl[i].o, tbl[i].z,
         $sformatf("vec%0d", i));

    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 20; i++) begin
        rm = 1'($urandom);
        ra = 16'($urandom);
        rb = 16'($urandom);
        model(width_of(s), rm, ra, rb, es, ec, eo, ez);
        op(s, rm, ra, rb, es, ec, eo, ez, $sformatf("rand dut%0d #%0d", s, i));
      end
    end

    // Start held high: one operation per 5 cycles, outputs frozen between dones.
    for (int i = 0; i < 4; i++) begin
      qa[i] = 16'($urandom);
      qb[i] = 16'($urandom);
      qm[i] = 1'($urandom);
    end
    hold = obs(1);
    @(negedge clk);
    drive(1, 1'b1, qm[0], qa[0], qb[0]);
    @(posedge clk);
    #1;
    drive_junk(1, 1'b1);
    cur = 0;
    cyc = 0;
    while (cur < 4 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      o = obs(1);
      if (o.done) begin
        model(8, qm[cur], qa[cur], qb[cur], es, ec, eo, ez);
        chk($sformatf("b2b%0d done_cycle", cur), 32'(cyc), 32'(4 + 5 * cur));
        chk($sformatf("b2b%0d result", cur), {13'h0, o.sum, o.cout, o.ovf, o.zero},
            {13'h0, es, ec, eo, ez});
        hold = o;
        cur++;
        if (cur < 4) drive(1, 1'b1, qm[cur], qa[cur], qb[cur]);
        else         drive_junk(1, 1'b0);
      end else begin
        chk($sformatf("b2b stable cyc%0d", cyc), {13'h0, o.sum, o.cout, o.ovf, o.zero},
            {13'h0, hold.sum, hold.cout, hold.ovf, hold.zero});
        drive_junk(1, 1'b1);
      end
    end
    chk("b2b completions", 32'(cur), 32'd4);
    repeat (3) begin
      @(posedge clk);
      #1;
      o = obs(1);
      chk("b2b idle_after", {30'h0, o.busy, o.done}, 32'd0);
    end

    // Asynchronous reset in the middle of an operation.
    op(1, 1'b0, 16'h0055, 16'h0022, 16'h0077, 1'b0, 1'b0, 1'b0, "pre_reset");
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 16'h0001, 16'h0001);
    @(posedge clk);
    #1;
    drive_junk(1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) chk($sformatf("midrun_reset dut%0d", s), 32'(obs(s)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      o = obs(1);
      chk("no_done_after_reset", {30'h0, o.busy, o.done}, 32'd0);
    end
    op(1, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
